coin_feeder: RTL and testbench

- Upstream front-end for the vending FSM.
- Synchronises raw coin-mechanism lines and edge-detects them into coin events.
- Queues coin events in a small FIFO and latches the customer's product selection.
- Presents one coin code per cycle on inp[2:0] with a stable product[1:0], in the 5-unit code the vending FSM consumes (1=5, 2=10, 5=25).

---
 rtl/coin_feeder_if.sv | 30 +++
 rtl/coin_feeder.sv | 139 +++++++++++++
 tb/tb_coin_feeder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/coin_feeder_if.sv
// Coin feeder handshake bundle: raw coin lines and selection in, coin codes out.
interface coin_feeder_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          coin_nickel;
    logic          coin_dime;
    logic          coin_quarter;
    logic          sel_valid;
    logic [1:0]    sel_code;
    logic          vend_done;
    logic [2:0]    inp;
    logic [1:0]    product;
    logic          armed;
    logic          coin_reject;
    logic [LW-1:0] fifo_level;

    modport master (
        output coin_nickel, coin_dime, coin_quarter,
        output sel_valid, sel_code, vend_done,
        input  inp, product, armed, coin_reject, fifo_level
    );

    modport slave (
        input  coin_nickel, coin_dime, coin_quarter,
        input  sel_valid, sel_code, vend_done,
        output inp, product, armed, coin_reject, fifo_level
    );
endinterface

// File: rtl/coin_feeder.sv
// Coin front-end: sync + edge detect, coin FIFO, product latch for the vending FSM.
// Optional idle auto-cancel in ARMED: define COIN_FEEDER_AUTO_CANCEL_EN.
module coin_feeder #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic         clk,
    input logic         rst,
    coin_feeder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, ARMED} state_e;

    state_e        state_q;
    logic [2:0]    s1_q, s2_q, s3_q;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [2:0]    inp_q;
    logic [1:0]    prod_q;
    logic          armed_q, rej_q;

    logic [2:0] raw, edge_w, code_w;
    logic       multi, single, full, empty;
    logic       push, pop, drop, flush;

    assign raw    = {bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
    assign edge_w = s2_q & ~s3_q;
    assign multi  = (edge_w[0] & edge_w[1]) | (edge_w[0] & edge_w[2])
                  | (edge_w[1] & edge_w[2]);
    assign single = |edge_w & ~multi;
    assign full   = cnt_q == LW'(DEPTH);
    assign empty  = cnt_q == '0;
    assign pop    = (state_q == ARMED) & ~empty;
    assign push   = single & ~full & ~flush;
    assign drop   = multi | (single & full);

    always_comb begin
        code_w = 3'd0;
        case (edge_w)
            3'b001:  code_w = 3'd1;
            3'b010:  code_w = 3'd2;
            3'b100:  code_w = 3'd5;
            default: code_w = 3'd0;
        endcase
    end

`ifdef COIN_FEEDER_AUTO_CANCEL_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    // Idle cycles count up while armed; the last one cancels the purchase.
    assign flush = (state_q == ARMED) & ~pop
                 & (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + LW'(1);
                2'b01:   cnt_d = cnt_q - LW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= code_w;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            inp_q   <= '0;
            prod_q  <= '0;
            armed_q <= 1'b0;
            rej_q   <= 1'b0;
`ifdef COIN_FEEDER_AUTO_CANCEL_EN
            tmo_q   <= '0;
`endif
        end else begin
            s1_q  <= raw;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            rej_q <= drop | flush;
            inp_q <= pop ? mem_q[rd_q] : 3'd0;
            unique case (state_q)
                IDLE: begin
                    if (bus.sel_valid) begin
                        state_q <= ARMED;
                        prod_q  <= bus.sel_code;
                        armed_q <= 1'b1;
                    end
`ifdef COIN_FEEDER_AUTO_CANCEL_EN
                    tmo_q <= '0;
`endif
                end
                ARMED: begin
                    if (flush || bus.vend_done) begin
                        state_q <= IDLE;
                        prod_q  <= 2'd0;
                        armed_q <= 1'b0;
                    end
`ifdef COIN_FEEDER_AUTO_CANCEL_EN
                    tmo_q <= pop ? '0 : tmo_q + TW'(1);
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.inp         = inp_q;
    assign bus.product     = prod_q;
    assign bus.armed       = armed_q;
    assign bus.coin_reject = rej_q;
    assign bus.fifo_level  = cnt_q;
endmodule

// File: tb/tb_coin_feeder.sv
// Directed bench for coin_feeder with a coin-code scoreboard queue.
module tb_coin_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   sb[$];

    coin_feeder_if #(.DEPTH(4)) bus ();

    coin_feeder #(.DEPTH(4), .TIMEOUT_CYC(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) e = 32'hFFFF_FFFF;
        else e = sb.pop_front();
        chk(tag, {29'd0, bus.inp}, e);
    endtask

    task automatic arm(input logic [1:0] code);
        bus.sel_valid = 1'b1;
        bus.sel_code  = code;
        cyc();
        bus.sel_valid = 1'b0;
    endtask

    initial begin
        bus.coin_nickel  = 1'b0;
        bus.coin_dime    = 1'b0;
        bus.coin_quarter = 1'b0;
        bus.sel_valid    = 1'b0;
        bus.sel_code     = 2'd0;
        bus.vend_done    = 1'b0;
        repeat (2) cyc();
        chk("rst_inp", {29'd0, bus.inp}, 0);
        chk("rst_product", {30'd0, bus.product}, 0);
        chk("rst_armed", {31'd0, bus.armed}, 0);
        chk("rst_reject", {31'd0, bus.coin_reject}, 0);
        chk("rst_level", {29'd0, bus.fifo_level}, 0);
        rst = 1'b1;
        cyc();

        // single dime after arming with product 2
        arm(2'd2);
        chk("t1_armed", {31'd0, bus.armed}, 1);
        chk("t1_product", {30'd0, bus.product}, 2);
        bus.coin_dime = 1'b1;
        sb.push_back(2);
        cyc();
        cyc();
        bus.coin_dime = 1'b0;
        cyc();
        chk("t1_early", {29'd0, bus.inp}, 0);
        chk("t1_level", {29'd0, bus.fifo_level}, 1);
        cyc();
        chk_pop("t1_inp");
        chk("t1_prod_hold", {30'd0, bus.product}, 2);
        cyc();
        chk("t1_once", {29'd0, bus.inp}, 0);
        chk("t1_drained", {29'd0, bus.fifo_level}, 0);
        bus.vend_done = 1'b1;
        cyc();
        bus.vend_done = 1'b0;
        chk("t1_idle", {31'd0, bus.armed}, 0);
        chk("t1_prod_clr", {30'd0, bus.product}, 0);

        // three coin types queued while idle, drained back-to-back
        bus.coin_nickel = 1'b1;
        sb.push_back(1);
        cyc();
        bus.coin_nickel = 1'b0;
        bus.coin_dime   = 1'b1;
        sb.push_back(2);
        cyc();
        bus.coin_dime    = 1'b0;
        bus.coin_quarter = 1'b1;
        sb.push_back(5);
        cyc();
        bus.coin_quarter = 1'b0;
        repeat (4) cyc();
        chk("t2_level", {29'd0, bus.fifo_level}, 3);
        chk("t2_idle_inp", {29'd0, bus.inp}, 0);
        arm(2'd3);
        chk("t2_product", {30'd0, bus.product}, 3);
        chk("t2_arm_inp", {29'd0, bus.inp}, 0);
        cyc();
        chk_pop("t2_pop0");
        cyc();
        chk_pop("t2_pop1");
        cyc();
        chk_pop("t2_pop2");
        cyc();
        chk("t2_after", {29'd0, bus.inp}, 0);
        chk("t2_level0", {29'd0, bus.fifo_level}, 0);
        bus.vend_done = 1'b1;
        cyc();
        bus.vend_done = 1'b0;

        // simultaneous nickel + quarter is rejected
        bus.coin_nickel  = 1'b1;
        bus.coin_quarter = 1'b1;
        cyc();
        cyc();
        bus.coin_nickel  = 1'b0;
        bus.coin_quarter = 1'b0;
        chk("t3_pre_rej", {31'd0, bus.coin_reject}, 0);
        cyc();
        chk("t3_reject", {31'd0, bus.coin_reject}, 1);
        chk("t3_level", {29'd0, bus.fifo_level}, 0);
        cyc();
        chk("t3_rej_end", {31'd0, bus.coin_reject}, 0);
        chk("t3_inp", {29'd0, bus.inp}, 0);

        // five nickels into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            bus.coin_nickel = 1'b1;
            if (i < 4) sb.push_back(1);
            cyc();
            bus.coin_nickel = 1'b0;
            cyc();
        end
        chk("t4_full", {29'd0, bus.fifo_level}, 4);
        chk("t4_no_rej", {31'd0, bus.coin_reject}, 0);
        cyc();
        chk("t4_reject", {31'd0, bus.coin_reject}, 1);
        chk("t4_sat", {29'd0, bus.fifo_level}, 4);
        cyc();
        chk("t4_rej_end", {31'd0, bus.coin_reject}, 0);

        // product holds against a new selection while armed
        arm(2'd1);
        chk("t5_product", {30'd0, bus.product}, 1);
        bus.sel_valid = 1'b1;
        bus.sel_code  = 2'd3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.sel_valid = 1'b0;
            chk_pop("t5_pop");
            chk("t5_hold", {30'd0, bus.product}, 1);
        end
        cyc();
        chk("t5_empty", {29'd0, bus.fifo_level}, 0);
        chk("t5_hold2", {30'd0, bus.product}, 1);
        bus.vend_done = 1'b1;
        cyc();
        bus.vend_done = 1'b0;
        chk("t5_prod_clr", {30'd0, bus.product}, 0);
        chk("t5_disarm", {31'd0, bus.armed}, 0);

        // idle-in-ARMED behaviour
        arm(2'd2);
`ifdef COIN_FEEDER_AUTO_CANCEL_EN
        repeat (9) cyc();
        chk("t6_still", {31'd0, bus.armed}, 1);
        cyc();
        chk("t6_cancel", {31'd0, bus.armed}, 0);
        chk("t6_rej", {31'd0, bus.coin_reject}, 1);
        chk("t6_level", {29'd0, bus.fifo_level}, 0);
        chk("t6_prod", {30'd0, bus.product}, 0);
`else
        repeat (30) cyc();
        chk("t6_stay", {31'd0, bus.armed}, 1);
        chk("t6_prod", {30'd0, bus.product}, 2);
        bus.vend_done = 1'b1;
        cyc();
        bus.vend_done = 1'b0;
`endif

        // reset mid-purchase drops the queue and product
        bus.coin_nickel = 1'b1;
        cyc();
        bus.coin_nickel = 1'b0;
        repeat (3) cyc();
        chk("t7_level", {29'd0, bus.fifo_level}, 1);
        arm(2'd2);
        rst = 1'b0;
        #1;
        chk("t7_rst_level", {29'd0, bus.fifo_level}, 0);
        chk("t7_rst_prod", {30'd0, bus.product}, 0);
        chk("t7_rst_armed", {31'd0, bus.armed}, 0);
        chk("t7_rst_inp", {29'd0, bus.inp}, 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
